// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter with a byte TX FIFO.
//
// Ports:
//   clk_i     - single clock, all state updates on its rising edge
//   rst_i     - synchronous active-high reset
//   wvalid_i  - dbus write strobe, one write per asserted cycle
//   awaddr_i  - write address, [3:2] selects TXDATA/STATUS/DIV/reserved
//   wdata_i   - write data
//   wstrb_i   - write byte enables
//   araddr_i  - read address, sampled every cycle, [3:2] selects the register
//   rdata_o   - registered read data, one cycle after araddr_i
//   txd_o     - serial output, 8N1, LSB first, idle high, driven from a flop
module dbus_uart_tx #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd867
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wvalid_i,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [ADDR_WIDTH-1:0]   araddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    txd_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e              state_q;
   logic [7:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic                ovf_q;
   logic [15:0]         div_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [7:0]          shift_q;
   logic [2:0]          bit_idx_q;
   logic [15:0]         baud_cnt_q;
   logic                txd_q;

   logic wr_txdata, wr_status, wr_div;
   logic fifo_full, fifo_empty;
   logic push, pop, ovf_set, ovf_clr;
   logic [DATA_WIDTH-1:0] status;
   logic [DATA_WIDTH-1:0] rd_mux;

   // Address bits outside [3:2] and data/strobe lanes above the 16-bit map are don't-care.
   logic unused_bits;
   assign unused_bits = ^{awaddr_i[ADDR_WIDTH-1:4], awaddr_i[1:0],
                          araddr_i[ADDR_WIDTH-1:4], araddr_i[1:0],
                          wdata_i[DATA_WIDTH-1:16], wstrb_i[STRB_WIDTH-1:2]};

   assign wr_txdata  = wvalid_i && (awaddr_i[3:2] == 2'd0);
   assign wr_status  = wvalid_i && (awaddr_i[3:2] == 2'd1);
   assign wr_div     = wvalid_i && (awaddr_i[3:2] == 2'd2);

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   // Fullness is judged before this cycle's pop, so a write into a full FIFO drops
   // even if the transmitter drains an entry on the same edge.
   assign push    = wr_txdata && wstrb_i[0] && !fifo_full;
   assign ovf_set = wr_txdata && wstrb_i[0] && fifo_full;
   assign ovf_clr = wr_status && wstrb_i[0] && wdata_i[3];
   assign pop     = (state_q == StIdle) && !fifo_empty;

   always_comb begin
      status                = '0;
      status[0]             = (state_q != StIdle);
      status[1]             = fifo_full;
      status[2]             = fifo_empty;
      status[3]             = ovf_q;
      status[8 +: CNT_W]    = count_q;
   end

   always_comb begin
      rd_mux = '0;
      case (araddr_i[3:2])
         2'd1:    rd_mux = status;
         2'd2:    rd_mux[15:0] = div_q;
         default: rd_mux = '0;
      endcase
   end

   // Register file, FIFO bookkeeping and read port.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DIV_RESET;
         rdata_q  <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr_q] <= wdata_i[7:0];
            wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         // Set wins over a same-cycle clear.
         ovf_q   <= ovf_set | (ovf_q & ~ovf_clr);
         if (wr_div && wstrb_i[0]) div_q[7:0]  <= wdata_i[7:0];
         if (wr_div && wstrb_i[1]) div_q[15:8] <= wdata_i[15:8];
         rdata_q <= rd_mux;
      end
   end

   // Transmit FSM. Each phase runs baud_cnt_q from DIV down to 0, so it lasts DIV+1
   // clocks; DIV is re-read only when a new bit is loaded.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         txd_q      <= 1'b1;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         baud_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q    <= fifo_mem[rd_ptr_q];
                  baud_cnt_q <= div_q;
                  txd_q      <= 1'b0;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               if (baud_cnt_q == 16'd0) begin
                  baud_cnt_q <= div_q;
                  bit_idx_q  <= 3'd0;
                  txd_q      <= shift_q[0];
                  state_q    <= StData;
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            StData: begin
               if (baud_cnt_q == 16'd0) begin
                  baud_cnt_q <= div_q;
                  if (bit_idx_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     shift_q   <= shift_q >> 1;
                     txd_q     <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            StStop: begin
               if (baud_cnt_q == 16'd0) begin
                  txd_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rdata_o = rdata_q;
   assign txd_o   = txd_q;

endmodule
